vr_merge_buf: RTL and testbench

VR_MERGE_BUF -- requirements
Module: vr_merge_buf

---
 rtl/vr_merge_buf.sv | 144 ++++++++++++++
 tb/tb_vr_merge_buf.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vr_merge_buf.sv
// vr_merge_buf: aligns MERGE_N valid/ready channels into one wide merged beat.
// Latency: 2 cycles from the last enabled channel accepted to o_valid high.
// Backpressure: per-channel DEPTH-entry FIFOs; o_ready comes from registered fullness only.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_en                 requested channel-enable mask (sampled only while idle)
//   i_valid/o_ready      per-channel upstream handshake
//   i_data               upstream payloads, channel k at [k*DATA_W +: DATA_W]
//   o_valid/i_ready      merged downstream handshake
//   o_data, o_en         merged payload and the enable mask it was built with
//   o_busy               any FIFO or the output register holds data

// Generic single-clock FIFO. The caller never pushes when full and never pops
// when empty.
module vr_merge_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: the count guards every read.
  always_ff @(posedge i_clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end
endmodule

module vr_merge_buf #(
  parameter int MERGE_N = 8,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [MERGE_N-1:0]        i_en,
  input  logic [MERGE_N-1:0]        i_valid,
  output logic [MERGE_N-1:0]        o_ready,
  input  logic [MERGE_N*DATA_W-1:0] i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [MERGE_N*DATA_W-1:0] o_data,
  output logic [MERGE_N-1:0]        o_en,
  output logic                      o_busy
);
  logic [MERGE_N-1:0]        en_q;
  logic [MERGE_N-1:0]        full;
  logic [MERGE_N-1:0]        empty;
  logic [MERGE_N-1:0]        push_vld;
  logic [MERGE_N-1:0]        pop_vld;
  logic [MERGE_N*DATA_W-1:0] head_dat;
  logic [MERGE_N*DATA_W-1:0] merged_dat;
  logic                      pop_all;

  for (genvar k = 0; k < MERGE_N; k++) begin : g_ch
    vr_merge_fifo #(
      .W     (DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .push_vld (push_vld[k]),
      .push_dat (i_data[k*DATA_W +: DATA_W]),
      .pop_vld  (pop_vld[k]),
      .head_dat (head_dat[k*DATA_W +: DATA_W]),
      .full     (full[k]),
      .empty    (empty[k])
    );

    // Disabled slots are forced to zero in the merged beat.
    assign merged_dat[k*DATA_W +: DATA_W] = en_q[k] ? head_dat[k*DATA_W +: DATA_W] : '0;
  end

  // Ready depends only on flops, so no combinational path from i_ready/i_valid.
  // A full FIFO refuses a push even if it is popped on the same edge.
  assign o_ready  = en_q & ~full;
  assign push_vld = i_valid & o_ready;

  // All enabled channels advance together once each has a beat waiting and
  // the output register is free or being drained this cycle.
  assign pop_all = (|en_q) && ((en_q & empty) == '0) && (!o_valid || i_ready);
  assign pop_vld = pop_all ? en_q : '0;

  // Disabled channels never receive pushes, so their FIFOs stay empty.
  assign o_busy = o_valid | (|(~empty));

  // The active mask only follows i_en while nothing is in flight, so a beat
  // is never split across two different masks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q <= '0;
    end else if (!o_busy) begin
      en_q <= i_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_en    <= '0;
    end else if (pop_all) begin
      o_valid <= 1'b1;
      o_data  <= merged_dat;
      o_en    <= en_q;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vr_merge_buf.sv
module tb_vr_merge_buf;
  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   i_en = '0;
  logic [N-1:0]   i_valid = '0;
  logic [N-1:0]   o_ready;
  logic [N*W-1:0] i_data = '0;
  logic           o_valid;
  logic           i_ready = 1'b0;
  logic [N*W-1:0] o_data;
  logic [N-1:0]   o_en;
  logic           o_busy;

  always #5 clk = ~clk;

  vr_merge_buf #(.MERGE_N(N), .DATA_W(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (i_en),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_en    (o_en),
    .o_busy  (o_busy)
  );

  typedef struct packed {
    logic [N*W-1:0] dat;
    logic [N-1:0]   en;
  } beat_t;

  // Scoreboard: accepted beats per channel, and merged beats still owed.
  beat_t        exp_q[$];
  logic [W-1:0] chm [N][256];
  int           wp [N];
  int           rp [N];
  logic [N-1:0] en_m = '0;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           busy_m;
  bit           all_rdy;
  beat_t        mon_b;

  function automatic void model_clear();
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      wp[k] = 0;
      rp[k] = 0;
    end
    en_m = '0;
  endfunction

  initial model_clear();

  // Negedge monitor: looks at what will happen on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      en_m = '0;
    end else begin
      busy_m = (exp_q.size() != 0);
      for (int k = 0; k < N; k++) if (rp[k] != wp[k]) busy_m = 1'b1;
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: got data=%h en=%b, required no beat", o_data, o_en);
        end else begin
          mon_b = exp_q.pop_front();
          if (o_data !== mon_b.dat || o_en !== mon_b.en)
            $display("FAIL beat_data: got data=%h en=%b, required data=%h en=%b",
                     o_data, o_en, mon_b.dat, mon_b.en);
          else
            n_pass++;
        end
      end
      if (!busy_m) en_m = i_en;
      for (int k = 0; k < N; k++) begin
        if (i_valid[k] && o_ready[k]) begin
          chm[k][wp[k] % 256] = i_data[k*W +: W];
          wp[k]++;
        end
      end
      for (int r = 0; r < 4; r++) begin
        all_rdy = (en_m != '0);
        for (int k = 0; k < N; k++) if (en_m[k] && rp[k] == wp[k]) all_rdy = 1'b0;
        if (!all_rdy) break;
        mon_b.dat = '0;
        mon_b.en  = en_m;
        for (int k = 0; k < N; k++) begin
          if (en_m[k]) begin
            mon_b.dat[k*W +: W] = chm[k][rp[k] % 256];
            rp[k]++;
          end
        end
        exp_q.push_back(mon_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [N-1:0] m);
    i_en = m;
    tick();
    tick();
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s_drain: o_busy=%b after 60 cycles, required 0", nm, o_busy);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #22;
    n_checks++;
    if ({o_valid, o_busy} !== 2'b00) $display("FAIL rst_valid_busy: got %b, required 00", {o_valid, o_busy});
    else n_pass++;
    n_checks++;
    if (o_ready !== 4'b0000) $display("FAIL rst_ready: got %b, required 0000", o_ready);
    else n_pass++;
    n_checks++;
    if ({o_en, o_data} !== '0) $display("FAIL rst_out: got en=%b data=%h, required zeros", o_en, o_data);
    else n_pass++;
    tick();
    i_en = 4'b1111;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 4'b0000) $display("FAIL rst_release_ready: got %b, required 0000 before first edge", o_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (o_ready !== 4'b1111) $display("FAIL rst_en_load: got o_ready=%b, required 1111", o_ready);
    else n_pass++;
  endtask

  task automatic test_full_rate();
    logic [13:0] vh;
    int          rdy_low;
    rdy_low = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) begin
        i_valid = 4'b1111;
        i_data  = {16'h3000 | 16'(i), 16'h2000 | 16'(i), 16'h1000 | 16'(i), 16'(i)};
      end else begin
        i_valid = '0;
      end
      @(negedge clk);
      vh[i] = o_valid;
      if (o_ready !== 4'b1111) rdy_low++;
      tick();
    end
    n_checks++;
    if (vh !== 14'h0FFC) $display("FAIL full_rate_valid: got %b, required %b", vh, 14'h0FFC);
    else n_pass++;
    n_checks++;
    if (rdy_low != 0) $display("FAIL full_rate_ready: got %0d cycles not ready, required 0", rdy_low);
    else n_pass++;
    wait_idle("full_rate");
  endtask

  task automatic test_sparse();
    bit             found;
    logic [N*W-1:0] got_d;
    logic [N-1:0]   got_e;
    found = 1'b0;
    got_d = '0;
    got_e = '0;
    tick();
    set_en(4'b0101);
    n_checks++;
    if (o_ready !== 4'b0101) $display("FAIL sparse_ready: got %b, required 0101", o_ready);
    else n_pass++;
    i_ready = 1'b1;
    i_valid = 4'b1111;
    i_data  = {16'h5555, 16'hBEEF, 16'hAAAA, 16'h1234};
    @(negedge clk);
    tick();
    i_valid = '0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (o_valid) begin
        found = 1'b1;
        got_d = o_data;
        got_e = o_en;
        break;
      end
      tick();
    end
    n_checks++;
    if (!found || got_d !== 64'h0000_BEEF_0000_1234)
      $display("FAIL sparse_data: got found=%b data=%h, required 0000beef00001234", found, got_d);
    else n_pass++;
    n_checks++;
    if (got_e !== 4'b0101) $display("FAIL sparse_en: got %b, required 0101", got_e);
    else n_pass++;
    wait_idle("sparse");
  endtask

  task automatic test_backpressure();
    logic [W-1:0]   d;
    logic [N*W-1:0] ref_d;
    bit             acc, have_ref;
    int             n_acc, changes, ndel;
    n_acc = 0; changes = 0; ndel = 0; have_ref = 1'b0; ref_d = '0;
    tick();
    set_en(4'b0001);
    i_ready = 1'b0;
    d = 16'h0100;
    i_valid = 4'b0001;
    i_data  = {48'h0, d};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = o_ready[0];
      if (o_valid) begin
        if (!have_ref) begin
          ref_d = o_data;
          have_ref = 1'b1;
        end else if (o_data !== ref_d) begin
          changes++;
        end
      end
      tick();
      if (acc) begin
        n_acc++;
        d = d + 16'h1;
        i_data = {48'h0, d};
      end
    end
    n_checks++;
    if (n_acc != 3) $display("FAIL bp_accepted: got %0d beats, required 3", n_acc);
    else n_pass++;
    n_checks++;
    if (o_ready[0] !== 1'b0) $display("FAIL bp_ready: got %b, required 0", o_ready[0]);
    else n_pass++;
    n_checks++;
    if (!have_ref || changes != 0) $display("FAIL bp_stable: got valid=%b changes=%0d, required 1 and 0", have_ref, changes);
    else n_pass++;
    i_valid = '0;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_valid && i_ready) ndel++;
      tick();
    end
    n_checks++;
    if (ndel != 3) $display("FAIL bp_delivered: got %0d beats, required 3", ndel);
    else n_pass++;
  endtask

  task automatic test_skew();
    logic [9:0] vh;
    tick();
    set_en(4'b0011);
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_valid = (i == 0) ? 4'b0010 : ((i == 5) ? 4'b0001 : 4'b0000);
      i_data  = {32'h0, 16'hC1C1, 16'hC0C0};
      @(negedge clk);
      vh[i] = o_valid;
      tick();
    end
    i_valid = '0;
    n_checks++;
    if (vh !== 10'b0010000000) $display("FAIL skew_valid: got %b, required 0010000000", vh);
    else n_pass++;
    wait_idle("skew");
  endtask

  task automatic test_en_change();
    bit found;
    found = 1'b0;
    tick();
    set_en(4'b1111);
    i_ready = 1'b0;
    i_valid = 4'b1111;
    i_data  = 64'h3333_2222_1111_0000;
    tick();
    i_valid = '0;
    i_en = 4'b0011;
    tick();
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1 || o_ready !== 4'b1111)
      $display("FAIL en_hold_busy: got busy=%b ready=%b, required 1 and 1111", o_busy, o_ready);
    else n_pass++;
    tick();
    i_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (!o_busy) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!found || o_ready !== 4'b1111)
      $display("FAIL en_drain_ready: got idle=%b ready=%b, required 1 and 1111", found, o_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (o_ready !== 4'b0011) $display("FAIL en_new_mask: got %b, required 0011", o_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nstale;
    nstale = 0;
    i_ready = 1'b0;
    i_valid = 4'b0011;
    i_data  = {32'h0, 16'hAAA1, 16'hAAA0};
    tick();
    i_data  = {32'h0, 16'hBBB1, 16'hBBB0};
    tick();
    i_valid = '0;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1)
      $display("FAIL mid_loaded: got valid=%b busy=%b, required 1 and 1", o_valid, o_busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL mid_async_clear: got valid=%b busy=%b, required 0 and 0", o_valid, o_busy);
    else n_pass++;
    n_checks++;
    if (o_ready !== 4'b0000) $display("FAIL mid_ready: got %b, required 0000", o_ready);
    else n_pass++;
    tick();
    i_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_valid) nstale++;
      tick();
    end
    n_checks++;
    if (nstale != 0) $display("FAIL mid_stale: got %0d valid cycles, required 0", nstale);
    else n_pass++;
    n_checks++;
    if (o_ready !== 4'b0011) $display("FAIL mid_reload: got %b, required 0011", o_ready);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_sparse();
    test_backpressure();
    test_skew();
    test_en_change();
    test_reset_mid();
    wait_idle("final");
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d beats owed, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
